// File: rtl/spi_xfer_ctrl_if.sv
// Signal bundle between spi_xfer_ctrl, the wishbone register file and spi_clkgen.
// The ss_n member exists only when SPI_XFER_AUTO_SS_EN is defined.
interface spi_xfer_ctrl_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 5
);
  logic               start;
  logic               abort;
  logic [LEN_W-1:0]   char_len;
  logic               lsb;
  logic               tx_neg;
  logic               rx_neg;
  logic [MAX_LEN-1:0] tx_data;
  logic               pos_edge;
  logic               neg_edge;
  logic               sclk_in;
  logic               miso;
  logic               tip;
  logic               go;
  logic               last_clk;
  logic               mosi;
  logic [MAX_LEN-1:0] rx_data;
  logic               done;
`ifdef SPI_XFER_AUTO_SS_EN
  logic               ss_n;

  modport master (
    output start, abort, char_len, lsb, tx_neg, rx_neg, tx_data,
    output pos_edge, neg_edge, sclk_in, miso,
    input  tip, go, last_clk, mosi, rx_data, done, ss_n
  );

  modport slave (
    input  start, abort, char_len, lsb, tx_neg, rx_neg, tx_data,
    input  pos_edge, neg_edge, sclk_in, miso,
    output tip, go, last_clk, mosi, rx_data, done, ss_n
  );
`else
  modport master (
    output start, abort, char_len, lsb, tx_neg, rx_neg, tx_data,
    output pos_edge, neg_edge, sclk_in, miso,
    input  tip, go, last_clk, mosi, rx_data, done
  );

  modport slave (
    input  start, abort, char_len, lsb, tx_neg, rx_neg, tx_data,
    input  pos_edge, neg_edge, sclk_in, miso,
    output tip, go, last_clk, mosi, rx_data, done
  );
`endif
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI character around spi_clkgen: shifts MOSI out, samples MISO in, pulses done.
// Optional automatic slave select (ss_n) is enabled by defining SPI_XFER_AUTO_SS_EN.
module spi_xfer_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 5
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  spi_xfer_ctrl_if.slave bus
);
  localparam int CW = LEN_W + 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TAIL, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]      len_reg, cnt_reg, start_len, tx_cnt;
  logic               lsb_reg, mosi_reg;
  logic [MAX_LEN-1:0] tx_reg, rx_sh_reg, rx_sh_next, rx_data_reg;
  logic [IW-1:0]      rx_bit, tx_bit, first_bit;
  logic               load_fire, rx_stb, tx_stb;
  logic               tip, go, last_clk, done;

  // Position in the character of the bit that is current while the counter holds c.
  function automatic logic [IW-1:0] bit_idx(input logic [CW-1:0] len,
                                            input logic [CW-1:0] c,
                                            input logic          lsb_first);
    return IW'(lsb_first ? len - c : c - CW'(1));
  endfunction

  assign load_fire = (state_reg == IDLE) && bus.start;
  assign start_len = (bus.char_len == '0) ? CW'(MAX_LEN) : {1'b0, bus.char_len};
  assign first_bit = bit_idx(start_len, start_len, bus.lsb);
  assign rx_stb    = (state_reg == SHIFT) && (bus.rx_neg ? bus.neg_edge : bus.pos_edge);
  assign tx_stb    = (state_reg == SHIFT) && (bus.tx_neg ? bus.neg_edge : bus.pos_edge);
  assign rx_bit    = bit_idx(len_reg, cnt_reg, lsb_reg);
  // The next MOSI bit is the one the receiver samples once this cycle's count update lands.
  assign tx_cnt    = rx_stb ? cnt_reg - CW'(1) : cnt_reg;
  assign tx_bit    = bit_idx(len_reg, tx_cnt, lsb_reg);

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_rx_bit
      assign rx_sh_next[gi] = load_fire                       ? 1'b0 :
                              (rx_stb && rx_bit == IW'(gi))   ? bus.miso :
                                                                rx_sh_reg[gi];
    end
  endgenerate

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tip        = 1'b0;
    go         = 1'b0;
    last_clk   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        tip        = 1'b1;
        go         = 1'b1;
        state_next = bus.abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        tip      = 1'b1;
        go       = 1'b1;
        last_clk = (cnt_reg == CW'(1));
        if (bus.abort)                          state_next = IDLE;
        else if (rx_stb && cnt_reg == CW'(1))   state_next = TAIL;
      end
      TAIL: begin
        tip      = 1'b1;
        go       = 1'b1;
        last_clk = 1'b1;
        if (bus.abort)         state_next = IDLE;
        else if (!bus.sclk_in) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      len_reg     <= '0;
      cnt_reg     <= '0;
      lsb_reg     <= 1'b0;
      tx_reg      <= '0;
      rx_sh_reg   <= '0;
      rx_data_reg <= '0;
      mosi_reg    <= 1'b0;
    end else begin
      rx_sh_reg <= rx_sh_next;
      if (load_fire) begin
        len_reg  <= start_len;
        cnt_reg  <= start_len;
        lsb_reg  <= bus.lsb;
        tx_reg   <= bus.tx_data;
        mosi_reg <= bus.tx_data[first_bit];
      end else begin
        if (rx_stb && cnt_reg != '0) cnt_reg  <= cnt_reg - CW'(1);
        if (tx_stb && tx_cnt != '0)  mosi_reg <= tx_reg[tx_bit];
      end
      if (state_reg == TAIL && state_next == DONE) rx_data_reg <= rx_sh_reg;
    end
  end

  assign bus.tip      = tip;
  assign bus.go       = go;
  assign bus.last_clk = last_clk;
  assign bus.done     = done;
  assign bus.mosi     = mosi_reg;
  assign bus.rx_data  = rx_data_reg;
`ifdef SPI_XFER_AUTO_SS_EN
  assign bus.ss_n     = (state_reg == IDLE);
`endif
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: the bench plays spi_clkgen and a loopback/pattern slave.
// Expected rx_data values go through a scoreboard queue popped on each done pulse.
module tb_spi_xfer_ctrl;
  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;

  spi_xfer_ctrl_if #(.MAX_LEN(32), .LEN_W(5)) bus ();

  spi_xfer_ctrl #(.MAX_LEN(32), .LEN_W(5)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [4:0]  char_len;
    logic        lsb;
    logic        tx_neg;
    logic        rx_neg;
    logic        loop;
    logic [31:0] tx_data;
    logic [31:0] miso_pat;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_q [$];
  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [31:0] prev_rx  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge wb_clk) begin
    if (!wb_rst && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(done_cnt), 32'(0));
      end else begin
        chk("sb_rx_data", bus.rx_data, exp_q.pop_front());
      end
`ifdef SPI_XFER_AUTO_SS_EN
      chk("ss_n_in_done", 32'(bus.ss_n), 32'(0));
`endif
    end
  end

  task automatic run_xfer(input vec_t v, input int abort_k, input bit start_mid);
    int          len, d0, p;
    logic [31:0] mask, mosi_w, last_w;
    len    = (v.char_len == 5'd0) ? 32 : int'(v.char_len);
    mask   = (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    mosi_w = '0;
    last_w = '0;
    d0     = done_cnt;

    bus.char_len = v.char_len;
    bus.lsb      = v.lsb;
    bus.tx_neg   = v.tx_neg;
    bus.rx_neg   = v.rx_neg;
    bus.tx_data  = v.tx_data;
    bus.start    = 1'b1;
    if (abort_k < 0) exp_q.push_back(v.exp_rx);
    tick;
    bus.start = 1'b0;
    chk("load_tip", 32'(bus.tip), 32'(1));
    chk("load_go", 32'(bus.go), 32'(1));
    chk("load_last_clk", 32'(bus.last_clk), 32'(0));
`ifdef SPI_XFER_AUTO_SS_EN
    chk("load_ss_n", 32'(bus.ss_n), 32'(0));
`endif
    tick;

    for (int k = 0; k < len; k++) begin
      if (k == abort_k) begin
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("abort_tip", 32'(bus.tip), 32'(0));
        chk("abort_go", 32'(bus.go), 32'(0));
        chk("abort_last_clk", 32'(bus.last_clk), 32'(0));
`ifdef SPI_XFER_AUTO_SS_EN
        chk("abort_ss_n", 32'(bus.ss_n), 32'(1));
`endif
        repeat (4) tick;
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_rx_hold", bus.rx_data, prev_rx);
        $display("xfer abort len=%0d after %0d bits rx_data=%h", len, k, bus.rx_data);
        return;
      end
      p = v.lsb ? k : (len - 1 - k);
      for (int ph = 0; ph < 2; ph++) begin
        if ((ph == 0) ? !v.rx_neg : v.rx_neg) begin
          mosi_w[p] = bus.mosi;
          last_w[k] = bus.last_clk;
          bus.miso  = v.loop ? bus.mosi : v.miso_pat[p];
        end
        bus.pos_edge = (ph == 0);
        bus.neg_edge = (ph == 1);
        bus.sclk_in  = (ph == 0);
        tick;
        bus.pos_edge = 1'b0;
        bus.neg_edge = 1'b0;
        bus.start    = start_mid && (k == 2) && (ph == 0);
        tick;
        bus.start    = 1'b0;
      end
    end

    for (int i = 0; i < 20 && done_cnt == d0; i++) tick;
    repeat (3) tick;
    chk("done_pulses", 32'(done_cnt - d0), 32'(1));
    chk("mosi_stream", mosi_w, v.tx_data & mask);
    chk("last_clk_final_only", last_w, 32'h1 << (len - 1));
    chk("idle_tip", 32'(bus.tip), 32'(0));
`ifdef SPI_XFER_AUTO_SS_EN
    chk("idle_ss_n", 32'(bus.ss_n), 32'(1));
`endif
    prev_rx = v.exp_rx;
    $display("xfer len=%0d lsb=%0d tx_neg=%0d rx_neg=%0d tx=%h rx_data=%h exp=%h",
             len, v.lsb, v.tx_neg, v.rx_neg, v.tx_data, bus.rx_data, v.exp_rx);
  endtask

  initial begin
    int d0;
    vecs[0] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00A5, 32'h0,         32'h0000_00A5};
    vecs[1] = '{5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0001, 32'h0,         32'h8000_0001};
    vecs[2] = '{5'd4,  1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0000_000C};
    vecs[3] = '{5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_003C, 32'h0,         32'h0000_003C};
    vecs[4] = '{5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_ABCD, 32'h0,         32'h0000_ABCD};
    vecs[5] = '{5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_005A, 32'h0000_005A};
    vecs[6] = '{5'd1,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0,         32'h0000_0001};
    vecs[7] = '{5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0ABC, 32'h0F0F_0F0F, 32'h0000_0F0F};

    bus.start = 1'b0; bus.abort = 1'b0; bus.char_len = '0; bus.lsb = 1'b0;
    bus.tx_neg = 1'b0; bus.rx_neg = 1'b0; bus.tx_data = '0;
    bus.pos_edge = 1'b0; bus.neg_edge = 1'b0; bus.sclk_in = 1'b0; bus.miso = 1'b0;

    wb_rst = 1'b1;
    repeat (2) tick;
    chk("rst_tip", 32'(bus.tip), 32'(0));
    chk("rst_go", 32'(bus.go), 32'(0));
    chk("rst_last_clk", 32'(bus.last_clk), 32'(0));
    chk("rst_mosi", 32'(bus.mosi), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_rx_data", bus.rx_data, 32'h0);
`ifdef SPI_XFER_AUTO_SS_EN
    chk("rst_ss_n", 32'(bus.ss_n), 32'(1));
`endif
    wb_rst = 1'b0;
    tick;

    // start and abort together in IDLE: start wins, then abort in LOAD returns to IDLE
    bus.char_len = 5'd8;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("start_wins_tip", 32'(bus.tip), 32'(1));
    tick;
    bus.abort = 1'b0;
    chk("load_abort_tip", 32'(bus.tip), 32'(0));
    repeat (3) tick;
    chk("load_abort_no_done", 32'(done_cnt), 32'(0));
    $display("xfer start+abort in IDLE then abort in LOAD, done_cnt=%0d", done_cnt);

    for (int i = 0; i < 8; i++) run_xfer(vecs[i], -1, 1'b0);

    // abort after three rx strobes, then a normal transfer; then start pulsed mid-SHIFT
    run_xfer(vecs[0], 3, 1'b0);
    run_xfer(vecs[3], -1, 1'b0);
    run_xfer(vecs[5], -1, 1'b1);

    // single-bit character: last_clk from first SHIFT cycle, done waits for sclk_in low
    d0 = done_cnt;
    bus.char_len = 5'd1; bus.lsb = 1'b0; bus.tx_neg = 1'b1; bus.rx_neg = 1'b0;
    bus.tx_data = 32'hFFFF_FFFE;
    bus.start = 1'b1;
    exp_q.push_back(32'h0);
    tick;
    bus.start = 1'b0;
    tick;
    chk("len1_last_clk_shift", 32'(bus.last_clk), 32'(1));
    bus.miso = bus.mosi; bus.pos_edge = 1'b1; bus.sclk_in = 1'b1;
    tick;
    bus.pos_edge = 1'b0;
    chk("len1_tail_last_clk", 32'(bus.last_clk), 32'(1));
    chk("len1_tail_no_done", 32'(bus.done), 32'(0));
    tick;
    chk("len1_tail_holds_tip", 32'(bus.tip), 32'(1));
    bus.sclk_in = 1'b0; bus.neg_edge = 1'b1;
    tick;
    bus.neg_edge = 1'b0;
    chk("len1_done", 32'(bus.done), 32'(1));
    chk("len1_cnt_zero", 32'(dut.cnt_reg), 32'(0));
    repeat (3) tick;
    chk("len1_done_pulses", 32'(done_cnt - d0), 32'(1));
    $display("xfer len=1 lsb=0 tx=%h rx_data=%h exp=%h", bus.tx_data, bus.rx_data, 32'h0);

    // reset in the middle of a transfer: no done, everything cleared
    d0 = done_cnt;
    bus.char_len = 5'd8; bus.tx_data = 32'h0000_00C3;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    bus.pos_edge = 1'b1; bus.sclk_in = 1'b1;
    tick;
    bus.pos_edge = 1'b0; bus.sclk_in = 1'b0;
    wb_rst = 1'b1;
    tick;
    chk("midrst_tip", 32'(bus.tip), 32'(0));
    chk("midrst_go", 32'(bus.go), 32'(0));
    chk("midrst_rx_data", bus.rx_data, 32'h0);
    wb_rst = 1'b0;
    repeat (4) tick;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'(0));
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("xfer reset mid-transfer, tip=%0d rx_data=%h", bus.tip, bus.rx_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
